// File: rtl/dmem_ctrl.sv
// MA-stage load/store controller: pipeline read/write requests to a word memory with busywait.
// Sub-word stores are performed as read-modify-write; bad requests answer with err and never touch memory.
module dmem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        read,
    input  logic [2:0]        write,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              busywait,
    output logic              err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_busywait
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    state_t      state_r;
    state_t      state_s;

    logic        req_present_s;
    logic        req_err_s;
    logic        req_sw_s;
    logic [31:0] load_result_s;
    logic [31:0] merged_s;

    logic [1:0]  lane_r;
    logic [2:0]  funct_r;
    logic [31:0] wdata_r;
    logic        load_r;

    // Little-endian lane extraction with sign/zero extension selected by funct3.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  funct3);
        logic [31:0] shifted;
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        shifted = word >> {lane, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            3'b000:  extract_load = {{24{byte_v[7]}}, byte_v};
            3'b001:  extract_load = {{16{half_v[15]}}, half_v};
            3'b100:  extract_load = {24'h000000, byte_v};
            3'b101:  extract_load = {16'h0000, half_v};
            default: extract_load = word;
        endcase
    endfunction

    // Replace the addressed byte/half lane of a word with store data, keeping other lanes.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size);
        logic [31:0] merged;
        merged = word;
        case (size)
            2'b00:   merged[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01:   merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
        return merged;
    endfunction

    // Classify the request presented on the pipeline side.
    always_comb begin
        req_present_s = read[3] | write[2];
        req_err_s     = 1'b0;
        req_sw_s      = 1'b0;
        if (read[3] && write[2]) begin
            req_err_s = 1'b1;
        end else if (read[3]) begin
            case (read[2:0])
                3'b000, 3'b100: req_err_s = 1'b0;
                3'b001, 3'b101: req_err_s = address[0];
                3'b010:         req_err_s = |address[1:0];
                default:        req_err_s = 1'b1;
            endcase
        end else if (write[2]) begin
            case (write[1:0])
                2'b00:   req_err_s = 1'b0;
                2'b01:   req_err_s = address[0];
                2'b10: begin
                    req_err_s = |address[1:0];
                    req_sw_s  = 1'b1;
                end
                default: req_err_s = 1'b1;
            endcase
        end else begin
            req_err_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; memory phases complete on an edge with mem_busywait low.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!req_present_s) begin
                    state_s = ST_IDLE;
                end else if (req_err_s) begin
                    state_s = ST_RESP;
                end else if (req_sw_s) begin
                    state_s = ST_WR;
                end else begin
                    state_s = ST_RD;
                end
            end
            ST_RD: begin
                if (mem_busywait) begin
                    state_s = ST_RD;
                end else if (load_r) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WR;
                end
            end
            ST_WR: begin
                if (mem_busywait) begin
                    state_s = ST_WR;
                end else begin
                    state_s = ST_RESP;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Combinational outputs: stall starts in the request cycle itself.
    always_comb begin
        busywait      = 1'b0;
        load_result_s = extract_load(mem_readdata, lane_r, funct_r);
        merged_s      = merge_store(mem_readdata, wdata_r, lane_r, funct_r[1:0]);
        case (state_r)
            ST_IDLE:      busywait = req_present_s;
            ST_RD, ST_WR: busywait = 1'b1;
            default:      busywait = 1'b0;
        endcase
    end

    // Capture the request so later states ignore changes on the pipeline inputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lane_r  <= 2'b00;
            funct_r <= 3'b000;
            wdata_r <= 32'h0000_0000;
            load_r  <= 1'b0;
        end else if (state_r == ST_IDLE && req_present_s) begin
            lane_r  <= address[1:0];
            funct_r <= read[3] ? read[2:0] : {1'b0, write[1:0]};
            wdata_r <= writedata;
            load_r  <= read[3];
        end
    end

    // Registered memory strobes, address, write word and response fields.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_addr      <= {ADDR_W{1'b0}};
            mem_writedata <= 32'h0000_0000;
            readdata      <= 32'h0000_0000;
            err           <= 1'b0;
        end else begin
            mem_read  <= (state_s == ST_RD);
            mem_write <= (state_s == ST_WR);
            err       <= (state_r == ST_IDLE) && req_present_s && req_err_s;
            case (state_r)
                ST_IDLE: begin
                    if (req_present_s && req_err_s) begin
                        readdata <= 32'h0000_0000;
                    end else if (req_present_s) begin
                        mem_addr <= {address[ADDR_W-1:2], 2'b00};
                        if (req_sw_s) begin
                            mem_writedata <= writedata;
                        end
                    end
                end
                ST_RD: begin
                    if (!mem_busywait && load_r) begin
                        readdata <= load_result_s;
                    end else if (!mem_busywait) begin
                        mem_writedata <= merged_s;
                    end
                end
                default: begin
                    mem_addr <= mem_addr;
                end
            endcase
        end
    end

    dmem_ctrl_chk u_chk (
        .clock       (clock),
        .reset       (reset),
        .busywait    (busywait),
        .err         (err),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr_lo (mem_addr[1:0])
    );

endmodule

// Protocol invariants of dmem_ctrl's memory-side and response outputs.
module dmem_ctrl_chk (
    input logic       clock,
    input logic       reset,
    input logic       busywait,
    input logic       err,
    input logic       mem_read,
    input logic       mem_write,
    input logic [1:0] mem_addr_lo
);

    a_strobe_excl: assert property (@(posedge clock) disable iff (!reset)
        !(mem_read && mem_write));

    a_word_addr: assert property (@(posedge clock) disable iff (!reset)
        mem_addr_lo == 2'b00);

    a_err_quiet: assert property (@(posedge clock) disable iff (!reset)
        err |-> (!busywait && !mem_read && !mem_write));

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Load/store controller that sits in the MA stage between the pipeline and a word-organised data memory with a busywait handshake. Accepts byte/half/word loads and stores using the pipeline's `read`/`write` encoding and performs little-endian lane extraction with sign/zero extension. Implements sub-word stores as read-modify-write on the word memory, and flags misaligned or conflicting requests without touching memory. Stalls the pipeline through `busywait` for the whole transaction.

## Interface
- `ADDR_W`, 32: byte address width on both sides.
- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low; asserted (0) forces all state and outputs to reset values.
- `read`  in  4  load request: [3] enable, [2:0] funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
- `write`  in  3  store request: [2] enable, [1:0] size (00 SB, 01 SH, 10 SW).
- `address`  in  ADDR_W  byte address of access.
- `writedata`  in  32  store data, right-justified.
- `readdata`  out  32  extended load result; valid in RESP.
- `busywait`  out  1  pipeline stall.
- `err`  out  1  misaligned/illegal request flag; valid in RESP.
- `mem_read`  out  1  word read request to memory.
- `mem_write`  out  1  word write request to memory.
- `mem_addr`  out  ADDR_W  word address, bits [1:0] always 00.
- `mem_writedata`  out  32  word to write.
- `mem_readdata`  in  32  word read from memory.
- `mem_busywait`  in  1  memory not yet complete.

## Operation
- FSM states: IDLE, RD, WR, RESP.
- Request valid = `read[3]` XOR `write[2]`; sampled only in IDLE. Both enables high = illegal; neither = no request.
- Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=00. Undefined funct3 (011, 110, 111; store size 11) = illegal.
- IDLE, any request (valid or not-neither): latch address, funct3/size, writedata, request type. Next: illegal/misaligned -> RESP with err=1; load or SB/SH -> RD; SW -> WR.
- RD: `mem_read`=1, `mem_addr`={addr[31:2],00}. Completion = rising edge with `mem_busywait`=0. On completion: load -> capture extracted result into `readdata`, go RESP; SB/SH -> merge store lanes into captured word, go WR.
- WR: `mem_write`=1, `mem_writedata` = full word (SW) or merged word. Completion as RD -> RESP.
- RESP: one cycle, `busywait`=0, then IDLE. Requester advances at the edge leaving RESP; new request accepted in next IDLE cycle, so no re-issue of the held request.
- Load extraction: byte lane = addr[1:0] (lane 0 = bits [7:0]); half lane = addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
- Store merge: SB replaces byte lane addr[1:0] with writedata[7:0]; SH replaces half lane addr[1] with writedata[15:0]; other lanes preserved.
- Error path: no memory request issued, `readdata`=0, `err`=1 in RESP only.
- Requester holds `read`, `write`, `address`, `writedata` stable while `busywait`=1; changes are ignored outside IDLE.

## Timing
- Reset values: state IDLE; `readdata`=0, `err`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_writedata`=0; `busywait`=0.
- `busywait` = (IDLE and request present) or state in {RD, WR}; combinational from IDLE inputs, so stall starts in the request cycle.
- `mem_read`/`mem_write` registered state decodes; held constant until completion edge; never both high.
- Zero-wait memory latency: LW/LB/LH/SW = 3 cycles (IDLE, RD|WR, RESP), stall 2; SB/SH = 4 cycles (IDLE, RD, WR, RESP), stall 3; error = 2 cycles, stall 1.
- Each `mem_busywait` cycle in RD/WR adds one cycle.
- Reset mid-transaction: immediate abort, requests drop asynchronously; memory write not guaranteed to land.

## Test plan
- Reset asserted mid-stream -> all outputs 0, state IDLE, `mem_write` drops without waiting for clock.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> `mem_writedata`=0xDEADBEEF at `mem_addr` 0x10; load `readdata`=0xDEADBEEF; `busywait` high exactly 2 cycles each.
- Word at 0x10 = 0xDEADBEEF; SB 0x13 data 0x000000A5 -> RD then WR of 0xA5ADBEEF, busywait 3 cycles; LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5.
- SH 0x12 data 0x00001234 onto 0xA5ADBEEF -> 0x1234BEEF; LH 0x10 -> 0xFFFFBEEF; LHU 0x10 -> 0x0000BEEF.
- LW 0x20 with `mem_busywait` high 3 cycles -> `mem_read` high 4 cycles, `busywait` high 5 cycles, result captured only on completion edge.
- LW 0x11, SH 0x13, and read[3]=write[2]=1 -> no `mem_read`/`mem_write`, `err`=1 and `readdata`=0 in RESP, busywait 1 cycle.
